// File: rtl/csr_trap_pkg.sv
// Shared types and constants for the CSR access/trap stage: FSM states,
// CSR addresses, trap cause code and the registered request record.
package csr_trap_pkg;

    localparam int DATA_W = 32;

    localparam logic [11:0] PROT_ADDR     = 12'h064;
    localparam logic [11:0] MSCRATCH_ADDR = 12'h340;
    localparam logic [11:0] MCAUSE_ADDR   = 12'h342;
    localparam logic [11:0] MTVAL_ADDR    = 12'h343;

    localparam logic [DATA_W-1:0] CAUSE_ILLEGAL = 32'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        TRAP  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [11:0]       addr;
        logic              we;
        logic              read;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        priv;
    } csr_req_t;

endpackage

// File: rtl/csr_regfile.sv
// Machine-level CSR storage: combinational read mux, address decode flags,
// committed writes to the writable CSRs and trap updates of mcause/mtval.
module csr_regfile
    import csr_trap_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    input  logic              trap_we,
    output logic [DATA_W-1:0] rdata,
    output logic              addr_valid,
    output logic              read_only
);

    logic [DATA_W-1:0] prot_q;
    logic [DATA_W-1:0] mscratch_q;
    logic [DATA_W-1:0] mcause_q;
    logic [DATA_W-1:0] mtval_q;

    always_comb begin
        rdata      = '0;
        addr_valid = 1'b1;
        read_only  = 1'b0;
        case (addr)
            PROT_ADDR:     rdata = prot_q;
            MSCRATCH_ADDR: rdata = mscratch_q;
            MCAUSE_ADDR: begin
                rdata     = mcause_q;
                read_only = 1'b1;
            end
            MTVAL_ADDR: begin
                rdata     = mtval_q;
                read_only = 1'b1;
            end
            default:       addr_valid = 1'b0;
        endcase
    end

    // Writes to read-only or unmapped addresses are trapped upstream, so
    // only the two writable CSRs need a write decode here.
    always_ff @(posedge clk) begin
        if (rst) begin
            prot_q     <= '0;
            mscratch_q <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_we) begin
            mcause_q <= CAUSE_ILLEGAL;
            mtval_q  <= {{(DATA_W-12){1'b0}}, addr};
        end else if (we) begin
            if (addr == PROT_ADDR)     prot_q     <= wdata;
            if (addr == MSCRATCH_ADDR) mscratch_q <= wdata;
        end
    end

endmodule

// File: rtl/csr_access_trap_unit.sv
// CSR access stage: registers a request, consults the external privilege
// checker, then commits or traps. Optional trap counter: CSR_TRAP_COUNT_EN.
module csr_access_trap_unit
    import csr_trap_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [11:0]       req_addr,
    input  logic              req_we,
    input  logic              req_read,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_priv,
    output logic              chk_csr_we,
    output logic              chk_csr_read,
    output logic [1:0]        chk_priv_lvl,
    output logic [11:0]       chk_csr_addr,
    input  logic              chk_exception,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              trap_valid,
    output logic [15:0]       trap_count
);

    // Handshakes: a transfer happens on a clock edge where valid && ready;
    // rsp_* stay stable while rsp_valid is high and rsp_ready is low.
    state_t            state;
    csr_req_t          req_q;
    logic [DATA_W-1:0] rf_rdata;
    logic              addr_valid;
    logic              read_only;
    logic              trap_hit;
    logic              commit_we;
    logic              in_check;

    assign in_check     = (state == CHECK);
    assign chk_csr_we   = in_check ? req_q.we   : 1'b0;
    assign chk_csr_read = in_check ? req_q.read : 1'b0;
    assign chk_priv_lvl = in_check ? req_q.priv : 2'd0;
    assign chk_csr_addr = in_check ? req_q.addr : 12'd0;

    assign trap_hit  = chk_exception
                     || ((req_q.we || req_q.read) && !addr_valid)
                     || (req_q.we && read_only);
    assign commit_we = in_check && !trap_hit && req_q.we;

    csr_regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .addr       (req_q.addr),
        .wdata      (req_q.wdata),
        .we         (commit_we),
        .trap_we    (state == TRAP),
        .rdata      (rf_rdata),
        .addr_valid (addr_valid),
        .read_only  (read_only)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_q      <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            trap_valid <= 1'b0;
        end else begin
            trap_valid <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_q     <= '{addr: req_addr, we: req_we, read: req_read,
                                       wdata: req_wdata, priv: req_priv};
                        req_ready <= 1'b0;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (trap_hit) begin
                        trap_valid <= 1'b1;
                        state      <= TRAP;
                    end else begin
                        // rf_rdata is the pre-write value, so read+write returns old data
                        rsp_rdata <= req_q.read ? rf_rdata : '0;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                TRAP: begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CSR_TRAP_COUNT_EN
    logic [15:0] trap_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            trap_count_q <= '0;
        end else if (trap_valid && (trap_count_q != 16'hFFFF)) begin
            trap_count_q <= trap_count_q + 16'd1;
        end
    end

    assign trap_count = trap_count_q;
`else
    assign trap_count = 16'd0;
`endif

endmodule

// File: tb/tb_csr_access_trap_unit.sv
// Bench for csr_access_trap_unit: vector table plus reset, back-pressure and
// trap-count sequences, with a scoreboard queue of expected responses.
module tb_csr_access_trap_unit;
    import csr_trap_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [11:0]       req_addr;
    logic              req_we;
    logic              req_read;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_priv;
    logic              chk_csr_we;
    logic              chk_csr_read;
    logic [1:0]        chk_priv_lvl;
    logic [11:0]       chk_csr_addr;
    logic              chk_exception;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              trap_valid;
    logic [15:0]       trap_count;

    int checks = 0;
    int errors = 0;
    int exp_traps = 0;
    logic [DATA_W:0] exp_q[$];

    typedef struct {
        logic [11:0]       addr;
        logic              we;
        logic              rd;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        priv;
        logic              err;
        logic [DATA_W-1:0] rdata;
        int                hold;
    } vec_t;

    vec_t vecs[18];

    csr_access_trap_unit dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_we        (req_we),
        .req_read      (req_read),
        .req_wdata     (req_wdata),
        .req_priv      (req_priv),
        .chk_csr_we    (chk_csr_we),
        .chk_csr_read  (chk_csr_read),
        .chk_priv_lvl  (chk_priv_lvl),
        .chk_csr_addr  (chk_csr_addr),
        .chk_exception (chk_exception),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .trap_valid    (trap_valid),
        .trap_count    (trap_count)
    );

    // Privilege checker: the protected CSR needs machine mode.
    assign chk_exception = (chk_csr_we || chk_csr_read)
                         && (chk_csr_addr == PROT_ADDR) && (chk_priv_lvl != 2'd3);

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic do_req(input logic [11:0] a, input logic w, input logic r,
                          input logic [DATA_W-1:0] d, input logic [1:0] p,
                          input logic e, input logic [DATA_W-1:0] x, input int hold);
        int lat;
        int tv_cnt;
        int tv_lat;
        int waitc;
        logic [DATA_W:0] exp;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = w;
        req_read  = r;
        req_wdata = d;
        req_priv  = p;
        exp_q.push_back({e, x});
        if (e) exp_traps++;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_read  = 1'b0;
        check("chk_addr", chk_csr_addr, a);
        check("chk_we_read", {chk_csr_we, chk_csr_read}, {w, r});
        check("chk_priv", chk_priv_lvl, p);
        lat = 1;
        tv_cnt = 0;
        tv_lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
            if (trap_valid) begin
                tv_cnt++;
                tv_lat = lat;
            end
        end
        check("rsp_latency", lat, e ? 3 : 2);
        check("trap_pulse_cnt", tv_cnt, e ? 1 : 0);
        check("trap_pulse_lat", tv_lat, e ? 2 : 0);
        check("chk_zero_outside", {chk_csr_we, chk_csr_read, chk_priv_lvl, chk_csr_addr}, 0);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check("rsp_err", rsp_err, exp[DATA_W]);
        check("rsp_rdata", rsp_rdata, exp[DATA_W-1:0]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_data", {rsp_err, rsp_rdata}, exp);
            check("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("req_ready_after_rsp", req_ready, 1);
        check("rsp_valid_drop", rsp_valid, 0);
    endtask

    initial begin
        int ev;
        logic [DATA_W-1:0] rnd;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_read  = 1'b0;
        req_wdata = '0;
        req_priv  = '0;
        rsp_ready = 1'b0;

        vecs[0]  = '{MSCRATCH_ADDR, 1, 0, 32'hDEADBEEF, 2'd3, 0, 32'h0,        0};
        vecs[1]  = '{MSCRATCH_ADDR, 0, 1, 32'h0,        2'd3, 0, 32'hDEADBEEF, 0};
        vecs[2]  = '{PROT_ADDR,     1, 0, 32'h1234,     2'd0, 1, 32'h0,        0};
        vecs[3]  = '{MCAUSE_ADDR,   0, 1, 32'h0,        2'd3, 0, 32'd2,        0};
        vecs[4]  = '{MTVAL_ADDR,    0, 1, 32'h0,        2'd3, 0, 32'h64,       0};
        vecs[5]  = '{PROT_ADDR,     0, 1, 32'h0,        2'd3, 0, 32'h0,        0};
        vecs[6]  = '{MCAUSE_ADDR,   1, 0, 32'h55,       2'd3, 1, 32'h0,        0};
        vecs[7]  = '{MCAUSE_ADDR,   0, 1, 32'h0,        2'd3, 0, 32'd2,        0};
        vecs[8]  = '{MTVAL_ADDR,    0, 1, 32'h0,        2'd3, 0, 32'h342,      0};
        vecs[9]  = '{12'h7C0,       0, 1, 32'h0,        2'd3, 1, 32'h0,        0};
        vecs[10] = '{MTVAL_ADDR,    0, 1, 32'h0,        2'd3, 0, 32'h7C0,      0};
        vecs[11] = '{MSCRATCH_ADDR, 1, 1, 32'hCAFE0001, 2'd3, 0, 32'hDEADBEEF, 0};
        vecs[12] = '{MSCRATCH_ADDR, 0, 1, 32'h0,        2'd3, 0, 32'hCAFE0001, 5};
        vecs[13] = '{12'h7C0,       0, 0, 32'h0,        2'd3, 0, 32'h0,        0};
        vecs[14] = '{PROT_ADDR,     1, 0, 32'hA5A5,     2'd3, 0, 32'h0,        0};
        vecs[15] = '{PROT_ADDR,     0, 1, 32'h0,        2'd1, 1, 32'h0,        0};
        vecs[16] = '{MTVAL_ADDR,    1, 0, 32'h77,       2'd3, 1, 32'h0,        0};
        vecs[17] = '{MTVAL_ADDR,    0, 1, 32'h0,        2'd3, 0, 32'h343,      0};

        repeat (2) @(negedge clk);
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        check("reset_trap", {trap_valid, trap_count}, 0);
        check("reset_chk", {chk_csr_we, chk_csr_read, chk_priv_lvl, chk_csr_addr}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_req_ready", req_ready, 1);

        for (int i = 0; i < 18; i++) begin
            do_req(vecs[i].addr, vecs[i].we, vecs[i].rd, vecs[i].wdata, vecs[i].priv,
                   vecs[i].err, vecs[i].rdata, vecs[i].hold);
        end
        do_req(PROT_ADDR, 0, 1, 0, 2'd3, 0, 32'hA5A5, 0);

        for (int i = 0; i < 3; i++) begin
            rnd = $urandom;
            do_req(MSCRATCH_ADDR, 1, 0, rnd, 2'($urandom_range(0, 3)), 0, 0, 0);
            do_req(MSCRATCH_ADDR, 0, 1, 0, 2'($urandom_range(0, 3)), 0, rnd, $urandom_range(0, 2));
        end

`ifdef CSR_TRAP_COUNT_EN
        check("trap_count_table", trap_count, exp_traps);
`else
        check("trap_count_table", trap_count, 0);
`endif

        // Reset while a trapping request sits in CHECK.
        req_valid = 1'b1;
        req_addr  = 12'h7C0;
        req_read  = 1'b1;
        req_priv  = 2'd3;
        @(negedge clk);
        req_valid = 1'b0;
        req_read  = 1'b0;
        check("mid_reset_in_check", chk_csr_addr, 12'h7C0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_req_ready", req_ready, 0);
        check("mid_reset_trap", trap_valid, 0);
        rst = 1'b0;
        ev = 0;
        @(negedge clk);
        check("mid_reset_ready_after", req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            if (trap_valid || rsp_valid) ev++;
            @(negedge clk);
        end
        check("mid_reset_no_events", ev, 0);
        check("mid_reset_trap_count", trap_count, 0);
        do_req(MCAUSE_ADDR, 0, 1, 0, 2'd3, 0, 32'h0, 0);
        do_req(MTVAL_ADDR, 0, 1, 0, 2'd3, 0, 32'h0, 0);

        for (int i = 0; i < 3; i++) begin
            do_req(12'h7C0 + 12'(i), 0, 1, 0, 2'd3, 1, 32'h0, 0);
        end
        do_req(MTVAL_ADDR, 0, 1, 0, 2'd3, 0, 32'h7C2, 0);
`ifdef CSR_TRAP_COUNT_EN
        check("trap_count_three", trap_count, 3);
`else
        check("trap_count_three", trap_count, 0);
`endif
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
